fb_write_arbiter: RTL and testbench

//  Shares the single write port (port A, CLOCK_50 domain) of the 320x240 dual-port video RAM

---
 rtl/vga_pkg.sv | 25 ++
 rtl/rr_arbiter.sv | 34 +++
 rtl/fb_write_arbiter.sv | 155 +++++++++++++++
 tb/tb_fb_write_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Frame-buffer geometry shared by the write arbiter and the VGA read-side address generator.
package vga_pkg;

  localparam int COLUMNS        = 320;
  localparam int ROWS           = 240;
  localparam int BITS_PER_PIXEL = 9;
  localparam int ADDR_WIDTH     = 17;
  localparam int FB_WORDS       = COLUMNS * ROWS;
  localparam int X_WIDTH        = 9;
  localparam int Y_WIDTH        = 8;

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_t;

  // y*320 + x as two shifts and adds; exact for any 9-bit x / 8-bit y in 17 bits.
  function automatic logic [ADDR_WIDTH-1:0] xy_to_addr(input logic [X_WIDTH-1:0] x,
                                                       input logic [Y_WIDTH-1:0] y);
    logic [ADDR_WIDTH-1:0] ye;
    ye = ADDR_WIDTH'(y);
    return (ye << 8) + (ye << 6) + ADDR_WIDTH'(x);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  // One extra bit so ptr+k cannot overflow before the wrap.
  logic [IDX_W:0] idx;
  logic           found;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + (IDX_W+1)'(k);
      if (idx >= (IDX_W+1)'(NUM_REQ)) begin
        idx = idx - (IDX_W+1)'(NUM_REQ);
      end
      if (!found && valid[idx[IDX_W-1:0]]) begin
        found                 = 1'b1;
        grant[idx[IDX_W-1:0]] = 1'b1;
        grant_idx             = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/fb_write_arbiter.sv
// Shares the video RAM write port among NUM_REQ pixel writers, with a built-in full-frame clear.
//   state    | meaning
//   ST_ARB   | round-robin pixel arbitration; clear_start takes priority
//   ST_CLEAR | clear engine owns the port, one word per cycle, requesters stalled
module fb_write_arbiter
  import vga_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                              CLOCK_50,
  input  logic                              resetn,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ*X_WIDTH-1:0]        req_x,
  input  logic [NUM_REQ*Y_WIDTH-1:0]        req_y,
  input  logic [NUM_REQ*BITS_PER_PIXEL-1:0] req_color,
  output logic [NUM_REQ-1:0]                req_ready,
  input  logic                              clear_start,
  input  logic [BITS_PER_PIXEL-1:0]         clear_color,
  output logic                              clear_busy,
  output logic                              clear_done,
  output logic                              pix_dropped,
  output logic                              fb_wren,
  output logic [ADDR_WIDTH-1:0]             fb_addr,
  output logic [BITS_PER_PIXEL-1:0]         fb_data
);

  localparam int                    IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [X_WIDTH-1:0]    X_LIM   = X_WIDTH'(COLUMNS);
  localparam logic [Y_WIDTH-1:0]    Y_LIM   = Y_WIDTH'(ROWS);
  localparam logic [ADDR_WIDTH-1:0] FB_LAST = ADDR_WIDTH'(FB_WORDS - 1);

  arb_state_t                state, state_next;
  logic [IDX_W-1:0]          ptr, ptr_next;
  logic [ADDR_WIDTH-1:0]     clr_cnt, clr_cnt_next;
  logic [BITS_PER_PIXEL-1:0] clr_color, clr_color_next;

  logic                      wren_next, dropped_next, done_next;
  logic [ADDR_WIDTH-1:0]     addr_next;
  logic [BITS_PER_PIXEL-1:0] data_next;

  logic [NUM_REQ-1:0]        grant, ready_int;
  logic [IDX_W-1:0]          grant_idx;
  logic [X_WIDTH-1:0]        sel_x;
  logic [Y_WIDTH-1:0]        sel_y;
  logic [BITS_PER_PIXEL-1:0] sel_color;
  logic                      in_range;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .valid     (req_valid),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_x     = '0;
    sel_y     = '0;
    sel_color = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_x     = req_x[i*X_WIDTH +: X_WIDTH];
        sel_y     = req_y[i*Y_WIDTH +: Y_WIDTH];
        sel_color = req_color[i*BITS_PER_PIXEL +: BITS_PER_PIXEL];
      end
    end
  end

  assign in_range = (sel_x < X_LIM) && (sel_y < Y_LIM);

  always_comb begin
    state_next     = state;
    ptr_next       = ptr;
    clr_cnt_next   = clr_cnt;
    clr_color_next = clr_color;
    wren_next      = 1'b0;
    addr_next      = '0;
    data_next      = '0;
    dropped_next   = 1'b0;
    done_next      = 1'b0;
    ready_int      = '0;
    case (state)
      ST_ARB: begin
        if (clear_start) begin
          state_next     = ST_CLEAR;
          clr_cnt_next   = '0;
          clr_color_next = clear_color;
          wren_next      = 1'b1;
          addr_next      = '0;
          data_next      = clear_color;
        end else if (|grant) begin
          ready_int = grant;
          ptr_next  = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
          if (in_range) begin
            wren_next = 1'b1;
            addr_next = xy_to_addr(sel_x, sel_y);
            data_next = sel_color;
          end else begin
            dropped_next = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        // clr_cnt is the address currently on fb_addr; stop once the last one is out.
        if (clr_cnt == FB_LAST) begin
          state_next = ST_ARB;
          done_next  = 1'b1;
        end else begin
          clr_cnt_next = clr_cnt + 1'b1;
          wren_next    = 1'b1;
          addr_next    = clr_cnt + 1'b1;
          data_next    = clr_color;
        end
      end
      default: state_next = ST_ARB;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (resetn) begin
      state <= ST_ARB;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (resetn) begin
      ptr         <= '0;
      clr_cnt     <= '0;
      clr_color   <= '0;
      fb_wren     <= 1'b0;
      fb_addr     <= '0;
      fb_data     <= '0;
      pix_dropped <= 1'b0;
      clear_done  <= 1'b0;
    end else begin
      ptr         <= ptr_next;
      clr_cnt     <= clr_cnt_next;
      clr_color   <= clr_color_next;
      fb_wren     <= wren_next;
      fb_addr     <= addr_next;
      fb_data     <= data_next;
      pix_dropped <= dropped_next;
      clear_done  <= done_next;
    end
  end

  // No handshake completes while reset is held.
  assign req_ready  = ready_int & {NUM_REQ{~resetn}};
  assign clear_busy = (state == ST_CLEAR);

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter: arbitration order, address mapping, drops, clear engine, reset.
module tb_fb_write_arbiter;

  logic        CLOCK_50;
  logic        resetn;
  logic [2:0]  req_valid;
  logic [26:0] req_x;
  logic [23:0] req_y;
  logic [26:0] req_color;
  logic [2:0]  req_ready;
  logic        clear_start;
  logic [8:0]  clear_color;
  logic        clear_busy;
  logic        clear_done;
  logic        pix_dropped;
  logic        fb_wren;
  logic [16:0] fb_addr;
  logic [8:0]  fb_data;

  int n_chk  = 0;
  int n_pass = 0;

  fb_write_arbiter #(.NUM_REQ(3)) dut (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .req_valid   (req_valid),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_color   (req_color),
    .req_ready   (req_ready),
    .clear_start (clear_start),
    .clear_color (clear_color),
    .clear_busy  (clear_busy),
    .clear_done  (clear_done),
    .pix_dropped (pix_dropped),
    .fb_wren     (fb_wren),
    .fb_addr     (fb_addr),
    .fb_data     (fb_data)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic set_req(input int i, input logic [8:0] x, input logic [7:0] y,
                         input logic [8:0] c);
    req_x[i*9 +: 9]     = x;
    req_y[i*8 +: 8]     = y;
    req_color[i*9 +: 9] = c;
  endtask

  int          bad;
  int          first_bad;
  logic [16:0] exp_addr [3];
  logic [8:0]  exp_data [3];

  initial begin
    resetn      = 1'b1;
    req_valid   = '0;
    req_x       = '0;
    req_y       = '0;
    req_color   = '0;
    clear_start = 1'b0;
    clear_color = '0;
    tick(); tick(); tick();

    chk("rst_wren",    32'(fb_wren), 0);
    chk("rst_addr",    32'(fb_addr), 0);
    chk("rst_data",    32'(fb_data), 0);
    chk("rst_busy",    32'(clear_busy), 0);
    chk("rst_done",    32'(clear_done), 0);
    chk("rst_dropped", 32'(pix_dropped), 0);
    chk("rst_ready",   32'(req_ready), 0);

    // single pixel from requester 0
    resetn = 1'b0;
    tick();
    set_req(0, 9'd5, 8'd2, 9'h1FF);
    req_valid = 3'b001;
    #1;
    chk("t1_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 3'b000;
    chk("t1_wren", 32'(fb_wren), 1);
    chk("t1_addr", 32'(fb_addr), 645);
    chk("t1_data", 32'(fb_data), 32'h1FF);
    chk("t1_dropped", 32'(pix_dropped), 0);

    // all three valid for 6 cycles from a fresh pointer
    resetn = 1'b1;
    tick(); tick();
    resetn = 1'b0;
    tick();
    set_req(0, 9'd10, 8'd0, 9'h011);
    set_req(1, 9'd11, 8'd1, 9'h022);
    set_req(2, 9'd12, 8'd2, 9'h033);
    exp_addr[0] = 17'd10;  exp_data[0] = 9'h011;
    exp_addr[1] = 17'd331; exp_data[1] = 9'h022;
    exp_addr[2] = 17'd652; exp_data[2] = 9'h033;
    req_valid = 3'b111;
    #1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("t2_ready_%0d", k), 32'(req_ready), 32'(1 << (k % 3)));
      tick();
      chk($sformatf("t2_wren_%0d", k), 32'(fb_wren), 1);
      chk($sformatf("t2_addr_%0d", k), 32'(fb_addr), 32'(exp_addr[k % 3]));
      chk($sformatf("t2_data_%0d", k), 32'(fb_data), 32'(exp_data[k % 3]));
    end
    req_valid = 3'b000;

    // off-screen drops and the last on-screen pixel
    set_req(0, 9'd320, 8'd0, 9'h100);
    req_valid = 3'b001;
    #1;
    chk("t3_ready_x", 32'(req_ready), 32'h1);
    tick();
    chk("t3_wren_x", 32'(fb_wren), 0);
    chk("t3_drop_x", 32'(pix_dropped), 1);
    set_req(0, 9'd0, 8'd240, 9'h100);
    #1;
    chk("t3_ready_y", 32'(req_ready), 32'h1);
    tick();
    chk("t3_wren_y", 32'(fb_wren), 0);
    chk("t3_drop_y", 32'(pix_dropped), 1);
    set_req(2, 9'd319, 8'd239, 9'h0F0);
    req_valid = 3'b100;
    #1;
    chk("t3_ready_last", 32'(req_ready), 32'h4);
    tick();
    req_valid = 3'b000;
    chk("t3_wren_last", 32'(fb_wren), 1);
    chk("t3_addr_last", 32'(fb_addr), 76799);
    chk("t3_data_last", 32'(fb_data), 32'h0F0);
    chk("t3_drop_last", 32'(pix_dropped), 0);
    tick();
    chk("t3_idle_wren", 32'(fb_wren), 0);
    chk("t3_idle_drop", 32'(pix_dropped), 0);

    // full clear with requester 1 pending; a second clear_start at write 1000 is ignored
    set_req(1, 9'd7, 8'd3, 9'h155);
    req_valid   = 3'b010;
    clear_start = 1'b1;
    clear_color = 9'h049;
    #1;
    chk("t4_ready_prio", 32'(req_ready), 0);
    tick();
    clear_start = 1'b0;
    clear_color = 9'h000;
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < 76800; i++) begin
      if (fb_wren !== 1'b1 || fb_addr !== 17'(i) || fb_data !== 9'h049 ||
          clear_busy !== 1'b1 || clear_done !== 1'b0 || req_ready !== 3'b000) begin
        if (bad == 0) first_bad = i;
        bad++;
      end
      if (i == 1000) begin
        clear_start = 1'b1;
        clear_color = 9'h1FF;
      end else begin
        clear_start = 1'b0;
      end
      tick();
    end
    chk("t4_clear_seq_bad", 32'(bad), 0);
    chk("t4_first_bad_write", 32'(first_bad), 32'hFFFF_FFFF);
    chk("t4_done",  32'(clear_done), 1);
    chk("t4_busy",  32'(clear_busy), 0);
    chk("t4_wren",  32'(fb_wren), 0);
    chk("t4_ready", 32'(req_ready), 32'h2);
    tick();
    req_valid = 3'b000;
    chk("t4_done_pulse", 32'(clear_done), 0);
    chk("t4_req_wren", 32'(fb_wren), 1);
    chk("t4_req_addr", 32'(fb_addr), 967);
    chk("t4_req_data", 32'(fb_data), 32'h155);

    // reset in the middle of a clear, then a fresh clear
    clear_start = 1'b1;
    clear_color = 9'h0AA;
    tick();
    clear_start = 1'b0;
    bad = 0;
    for (int i = 0; i <= 500; i++) begin
      if (fb_wren !== 1'b1 || fb_addr !== 17'(i) || fb_data !== 9'h0AA) bad++;
      if (i == 500) resetn = 1'b1;
      tick();
    end
    chk("t6_prefix_bad", 32'(bad), 0);
    chk("t6_rst_wren", 32'(fb_wren), 0);
    chk("t6_rst_addr", 32'(fb_addr), 0);
    chk("t6_rst_data", 32'(fb_data), 0);
    chk("t6_rst_busy", 32'(clear_busy), 0);
    chk("t6_rst_done", 32'(clear_done), 0);
    resetn = 1'b0;
    tick();
    chk("t6_no_done", 32'(clear_done), 0);
    chk("t6_idle_busy", 32'(clear_busy), 0);
    clear_start = 1'b1;
    clear_color = 9'h0C3;
    tick();
    clear_start = 1'b0;
    chk("t6_restart_wren", 32'(fb_wren), 1);
    chk("t6_restart_addr", 32'(fb_addr), 0);
    chk("t6_restart_data", 32'(fb_data), 32'h0C3);
    chk("t6_restart_busy", 32'(clear_busy), 1);
    tick();
    chk("t6_restart_addr1", 32'(fb_addr), 1);

    resetn = 1'b1;
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
